// File: rtl/timer_counter_core.sv
// Prescaled up/down timer counter: a free-running prescaler selects a tick rate,
// and the counter loads, counts on ticks, or holds, flagging wrap with ovf/udf pulses.
module timer_counter_core #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [CNT_W-1:0] tdr,
  input  logic             load,
  input  logic             dir,
  input  logic             en,
  input  logic [1:0]       cks,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             sel;
  logic             sel_dly_q, sel_dly_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] v,
                                                input logic down);
    return down ? v - CNT_W'(1) : v + CNT_W'(1);
  endfunction

  // Stage 0: prescaler and rising-edge tick detect (cks changes are not synchronized)
  always_comb begin
    pre_d     = pre_q + PRE_W'(1);
    sel       = pre_q[cks];
    sel_dly_d = sel;
    tick      = sel & ~sel_dly_q;
  end

  // Stage 1: counter update, load has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (load) begin
      cnt_d = tdr;
    end else if (en && tick) begin
      cnt_d = step_cnt(cnt_q, dir);
      ovf_d = ~dir & (cnt_q == '1);
      udf_d = dir & (cnt_q == '0);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre_q     <= '0;
      sel_dly_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      sel_dly_q <= sel_dly_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: doc/timer_counter_core.md
TIMER_COUNTER_CORE -- requirements
Module: timer_counter_core

Interface
REQ-001 Parameter: CNT_W, default 8, counter and load-data width in bits.
REQ-002 Parameter: PRE_W, default 4, prescaler width in bits; fixes the maximum divide ratio at 2^PRE_W.
REQ-003 The block SHALL use one clock and SHALL have an asynchronous, active-low reset.
REQ-004 Port: pclk, input, 1, system clock; all state updates on its rising edge.
REQ-005 Port: presetn, input, 1, asynchronous active-low reset.
REQ-006 Port: tdr, input, CNT_W, load value from the TDR register.
REQ-007 Port: load, input, 1, level; when 1, the counter is loaded from tdr.
REQ-008 Port: dir, input, 1, count direction: 0 = up, 1 = down.
REQ-009 Port: en, input, 1, level; enables counting on ticks.
REQ-010 Port: cks, input, 2, clock select: 00 = pclk/2, 01 = pclk/4, 10 = pclk/8, 11 = pclk/16.
REQ-011 Port: cnt, output, CNT_W, current counter value (TCNT), registered.
REQ-012 Port: ovf, output, 1, one-cycle overflow pulse, registered.
REQ-013 Port: udf, output, 1, one-cycle underflow pulse, registered.

Function
REQ-014 The prescaler SHALL be a PRE_W-bit free-running up counter that increments every pclk, independent of en and load.
REQ-015 sel SHALL equal prescaler bit cks (cks=00 selects bit0, 11 selects bit3); sel_d SHALL be sel registered one pclk later.
REQ-016 tick SHALL be the combinational term sel & ~sel_d, giving one pclk-wide tick per 2, 4, 8 or 16 pclk.
REQ-017 A cks change SHALL NOT be synchronized: if the newly selected bit is 1 while sel_d is 0, one tick results; at most one extra or one missing tick per change is permitted.
REQ-018 Update priority each edge: load, then count, then hold.
REQ-019 load=1: cnt <= tdr on every edge while asserted; ovf=udf=0 regardless of tick, en or dir.
REQ-020 Count condition: load=0, en=1, tick=1; dir=0 gives cnt <= cnt+1, dir=1 gives cnt <= cnt-1, modulo 2^CNT_W.
REQ-021 Up count from all-ones (0xFF) SHALL wrap to 0x00 and assert ovf for exactly the one cycle in which cnt=0x00 first appears.
REQ-022 Down count from 0x00 SHALL wrap to 0xFF and assert udf for exactly the one cycle in which cnt=0xFF first appears.
REQ-023 ovf and udf SHALL be 0 in every other cycle and SHALL never be asserted together.
REQ-024 en=0 or no tick (with load=0) SHALL hold cnt and drive ovf=udf=0.
REQ-025 A dir change takes effect on the next tick; there is no pipeline latency beyond the single register stage.
REQ-026 Latency: the cnt change and the ovf/udf pulse SHALL appear on the same edge as the qualifying tick.

Reset
REQ-027 presetn=0 SHALL immediately and asynchronously clear prescaler, sel_d, cnt, ovf and udf to 0.
REQ-028 A reset asserted mid-count SHALL drop any pending pulse; counting resumes from 0x00 with prescaler 0 after deassertion.
REQ-029 After deassertion, the first pclk/2 tick SHALL occur on the 2nd edge (prescaler bit0 0->1 at edge 1, detected at edge 2); clk16 first tick SHALL occur on edge 9.

Verification
REQ-030 Reset: presetn=0 for 3 pclk with arbitrary inputs -> cnt=0x00, ovf=0, udf=0 throughout; no tick-driven change during reset.
REQ-031 Up wrap: load tdr=0xF0, then dir=0, en=1, cks=00 -> cnt=0xFF after 15 ticks (30 pclk), cnt=0x00 with ovf=1 for one cycle on the 16th tick, udf=0 always.
REQ-032 Down clk16: load tdr=0xFF, then dir=1, en=1, cks=11 -> cnt=0x00 after 255 ticks with udf never asserted; at 256 ticks (4096 pclk) cnt=0xFF with a single udf pulse.
REQ-033 Hold: count to 0x37, set en=0 for 100 pclk -> cnt stays 0x37, ovf=udf=0; en=1 resumes at 0x38 on the next tick.
REQ-034 Load priority: cnt=0xFF, dir=0, load=1 with tdr=0x10 coincident with a tick -> cnt=0x10, no ovf pulse.
REQ-035 Async reset mid-count: cnt=0x55, presetn falls between edges -> cnt=0x00 before the next pclk edge; after release, first cks=00 tick on edge 2 gives cnt=0x01.
